// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN readout stage.
package snn_pkg;

  localparam int SNN_DATA_W  = 8;
  localparam int SNN_NUM_OUT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2,
    HOLD   = 2'd3
  } dec_state_t;

endpackage : snn_pkg

// File: rtl/snn_argmax3.sv
// Three-way argmax over spike counts. Purely combinational.
// Ties resolve to the lowest index; o_zero flags all counts equal to zero.
module snn_argmax3 #(
  parameter int CNT_W = 6
) (
  input  logic [CNT_W-1:0] i_cnt0,
  input  logic [CNT_W-1:0] i_cnt1,
  input  logic [CNT_W-1:0] i_cnt2,
  output logic [1:0]       o_idx,
  output logic [CNT_W-1:0] o_max,
  output logic             o_zero
);

  // Strict greater-than keeps the earlier index on equal counts.
  always_comb begin
    o_idx = 2'd0;
    o_max = i_cnt0;
    if (i_cnt1 > o_max) begin
      o_idx = 2'd1;
      o_max = i_cnt1;
    end
    if (i_cnt2 > o_max) begin
      o_idx = 2'd2;
      o_max = i_cnt2;
    end
    o_zero = ((i_cnt0 | i_cnt1 | i_cnt2) == '0);
  end

endmodule : snn_argmax3

// File: rtl/snn_spike_decoder.sv
// Spike-count readout for the three SNN output neurons.
// Counts spikes over a WINDOW-sample window, picks the winner with an argmax
// and holds the result on a valid/ready handshake.
// Optional build macro: SNN_DEC_EARLY_EXIT_EN ends the window as soon as any
// counter reaches EARLY_THRESH.
module snn_spike_decoder
  import snn_pkg::*;
#(
  parameter int WINDOW       = 16,
  parameter int CNT_W        = 6,
  parameter int SPIKE_MIN    = 1,
  parameter int EARLY_THRESH = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [7:0]       i_data0,
  input  logic [7:0]       i_data1,
  input  logic [7:0]       i_data2,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [1:0]       o_class,
  output logic [CNT_W-1:0] o_count,
  output logic             o_none
);

  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
  localparam logic [7:0]            WIN_LAST = 8'(WINDOW - 1);
  localparam logic [SNN_DATA_W-1:0] SPK_MIN  = SNN_DATA_W'(SPIKE_MIN);

  typedef logic [SNN_NUM_OUT-1:0][CNT_W-1:0] cnt_bank_t;

  dec_state_t state_q, state_d;
  cnt_bank_t  cnt_q, cnt_d, cnt_upd;
  logic [7:0] win_q, win_d;
  logic       valid_q, valid_d;
  logic [1:0] class_q, class_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic       none_q, none_d;

  logic [SNN_NUM_OUT-1:0][SNN_DATA_W-1:0] data_in;
  logic [SNN_NUM_OUT-1:0] spike;
  logic       early_hit;
  logic [1:0] am_idx;
  logic [CNT_W-1:0] am_max;
  logic       am_zero;

  assign data_in = {i_data2, i_data1, i_data0};

  // Spike detection and saturating per-neuron increment for this sample.
  always_comb begin
    for (int n = 0; n < SNN_NUM_OUT; n++) begin
      spike[n]   = (data_in[n] >= SPK_MIN);
      cnt_upd[n] = (spike[n] && (cnt_q[n] != CNT_MAX)) ? cnt_q[n] + CNT_W'(1) : cnt_q[n];
    end
  end

`ifdef SNN_DEC_EARLY_EXIT_EN
  // Early exit looks at the counts after this cycle's update.
  always_comb begin
    early_hit = 1'b0;
    for (int n = 0; n < SNN_NUM_OUT; n++) begin
      if (32'(cnt_upd[n]) >= 32'(EARLY_THRESH)) early_hit = 1'b1;
    end
  end
`else
  logic early_unused;
  assign early_unused = (EARLY_THRESH != 0);
  assign early_hit    = 1'b0;
`endif

  snn_argmax3 #(
    .CNT_W (CNT_W)
  ) u_argmax (
    .i_cnt0 (cnt_q[0]),
    .i_cnt1 (cnt_q[1]),
    .i_cnt2 (cnt_q[2]),
    .o_idx  (am_idx),
    .o_max  (am_max),
    .o_zero (am_zero)
  );

  // Next-state and datapath updates for the decode FSM.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    valid_d = valid_q;
    class_d = class_q;
    count_d = count_q;
    none_d  = none_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          cnt_d   = '0;
          win_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        cnt_d = cnt_upd;
        win_d = win_q + 8'd1;
        if ((win_q == WIN_LAST) || early_hit) state_d = DECIDE;
      end
      DECIDE: begin
        class_d = am_idx;
        count_d = am_max;
        none_d  = am_zero;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (i_start) begin
            cnt_d   = '0;
            win_d   = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      // NOTE: the counter bank is a handful of flops, so it is reset with the FSM rather than left undefined.
      cnt_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      class_q <= '0;
      count_q <= '0;
      none_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      class_q <= class_d;
      count_q <= count_d;
      none_q  <= none_d;
    end
  end

  assign o_busy  = (state_q == ACCUM) || (state_q == DECIDE);
  assign o_valid = valid_q;
  assign o_class = class_q;
  assign o_count = count_q;
  assign o_none  = none_q;

endmodule : snn_spike_decoder

// File: tb/tb_snn_spike_decoder.sv
// Scoreboard bench for snn_spike_decoder: u_a uses default counter width,
// u_b uses CNT_W=3 to exercise saturation. Expected results are pushed when a
// window is started; per-DUT monitors pop and compare on each handshake and
// check the held result while the consumer stalls.
module tb_snn_spike_decoder;

  localparam int WINDOW = 16;
  localparam int CNT_A  = 6;
  localparam int CNT_B  = 3;

`ifdef SNN_DEC_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // Latency counted in edges after the edge that sampled i_start
  // (WINDOW+2 edges when the sampling edge itself is included).
  localparam int LAT_FULL  = WINDOW + 1;
  localparam int LAT_EARLY = EARLY ? 9 : LAT_FULL;
  localparam int CNT16     = EARLY ? 8 : 16;

  typedef struct packed {
    logic [1:0] cls;
    logic [5:0] cnt;
    logic       none;
  } result_t;

  logic clk, rst_n;
  logic [7:0] d0, d1, d2;
  logic start_a, start_b, ready;
  logic busy_a, valid_a, none_a;
  logic [1:0] cls_a;
  logic [CNT_A-1:0] cnt_a;
  logic busy_b, valid_b, none_b;
  logic [1:0] cls_b;
  logic [CNT_B-1:0] cnt_b;

  result_t exp_a[$];
  result_t exp_b[$];
  int n_tests = 0;
  int n_fail  = 0;

  snn_spike_decoder #(
    .WINDOW(WINDOW), .CNT_W(CNT_A), .SPIKE_MIN(1), .EARLY_THRESH(8)
  ) u_a (
    .i_clk(clk), .i_rstn(rst_n),
    .i_data0(d0), .i_data1(d1), .i_data2(d2),
    .i_start(start_a), .o_busy(busy_a), .o_valid(valid_a), .i_ready(ready),
    .o_class(cls_a), .o_count(cnt_a), .o_none(none_a)
  );

  snn_spike_decoder #(
    .WINDOW(WINDOW), .CNT_W(CNT_B), .SPIKE_MIN(1), .EARLY_THRESH(8)
  ) u_b (
    .i_clk(clk), .i_rstn(rst_n),
    .i_data0(d0), .i_data1(d1), .i_data2(d2),
    .i_start(start_b), .o_busy(busy_b), .o_valid(valid_b), .i_ready(ready),
    .o_class(cls_b), .o_count(cnt_b), .o_none(none_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic result_t mk(input int c, input int n, input bit z);
    result_t r;
    r.cls  = 2'(c);
    r.cnt  = 6'(n);
    r.none = z;
    return r;
  endfunction

  // Monitor for u_a: compare on handshake, compare held value while stalled.
  always @(negedge clk) begin
    if (rst_n && valid_a) begin
      check("a_result_expected", int'(exp_a.size() > 0), 1);
      if (exp_a.size() > 0) begin
        if (ready) begin
          check("a_class", cls_a, exp_a[0].cls);
          check("a_count", cnt_a, exp_a[0].cnt);
          check("a_none",  none_a, exp_a[0].none);
          void'(exp_a.pop_front());
        end else begin
          check("a_hold_class", cls_a, exp_a[0].cls);
          check("a_hold_count", cnt_a, exp_a[0].cnt);
          check("a_hold_none",  none_a, exp_a[0].none);
        end
      end
    end
  end

  // Monitor for u_b.
  always @(negedge clk) begin
    if (rst_n && valid_b) begin
      check("b_result_expected", int'(exp_b.size() > 0), 1);
      if (exp_b.size() > 0) begin
        if (ready) begin
          check("b_class", cls_b, exp_b[0].cls);
          check("b_count", cnt_b, exp_b[0].cnt);
          check("b_none",  none_b, exp_b[0].none);
          void'(exp_b.pop_front());
        end else begin
          check("b_hold_class", cls_b, exp_b[0].cls);
          check("b_hold_count", cnt_b, exp_b[0].cnt);
          check("b_hold_none",  none_b, exp_b[0].none);
        end
      end
    end
  end

  task automatic drive_sample(input int k, input logic [15:0] m0, input logic [15:0] m1,
                              input logic [15:0] m2, input logic [7:0] v);
    if (k < WINDOW) begin
      d0 = m0[k] ? v : 8'd0;
      d1 = m1[k] ? v : 8'd0;
      d2 = m2[k] ? v : 8'd0;
    end else begin
      d0 = 8'd0; d1 = 8'd0; d2 = 8'd0;
    end
  endtask

  // Called just after the edge that sampled i_start; feeds samples and
  // measures edges until o_valid is seen.
  task automatic accum_and_wait(input bit sel, input logic [15:0] m0, input logic [15:0] m1,
                                input logic [15:0] m2, input logic [7:0] v,
                                input int exp_lat, input string name);
    int lat = -1;
    drive_sample(0, m0, m1, m2, v);
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (sel ? valid_b : valid_a) lat = n;
      drive_sample(n, m0, m1, m2, v);
    end
    d0 = 8'd0; d1 = 8'd0; d2 = 8'd0;
    check({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic wait_idle(input bit sel, input string name);
    int i = 0;
    while (i < 64 && (sel ? (busy_b || valid_b) : (busy_a || valid_a))) begin
      @(posedge clk); #1;
      i++;
    end
    check({name, "_reach_idle"}, int'(sel ? (busy_b || valid_b) : (busy_a || valid_a)), 0);
  endtask

  task automatic run_window(input bit sel, input logic [15:0] m0, input logic [15:0] m1,
                            input logic [15:0] m2, input logic [7:0] v,
                            input result_t exp, input int exp_lat, input string name);
    wait_idle(sel, name);
    if (sel) exp_b.push_back(exp);
    else     exp_a.push_back(exp);
    @(posedge clk); #1;
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    accum_and_wait(sel, m0, m1, m2, v, exp_lat, name);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; ready = 1'b1;
    d0 = 8'd0; d1 = 8'd0; d2 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",  busy_a, 0);
    check("reset_valid", valid_a, 0);
    check("reset_class", cls_a, 0);
    check("reset_count", cnt_a, 0);
    check("reset_none",  none_a, 0);
    check("reset_b_valid", valid_b, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_window(1'b0, 16'h0000, 16'hFFFF, 16'h0000, 8'd5,  mk(1, CNT16, 0), LAT_EARLY, "single_n1");
    run_window(1'b0, 16'h1111, 16'h0000, 16'h8421, 8'd77, mk(0, 4, 0),     LAT_FULL,  "tie_0_2");
    run_window(1'b0, 16'h0000, 16'h0000, 16'h0000, 8'd0,  mk(0, 0, 1),     LAT_FULL,  "all_zero");
    run_window(1'b0, 16'h0007, 16'h7F00, 16'h03FF, 8'd3,
               EARLY ? mk(2, 8, 0) : mk(2, 10, 0), LAT_EARLY, "distinct");
    run_window(1'b0, 16'h0001, 16'h0505, 16'h5050, 8'd128, mk(1, 4, 0),    LAT_FULL,  "tie_1_2");
    run_window(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 8'd1,  mk(0, CNT16, 0), LAT_EARLY, "min_spike_n0");

    // Reset three samples into a window; last result (class 0, nonzero count) must clear at once.
    wait_idle(1'b0, "rst_mid");
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    d1 = 8'd5;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst_pre_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_busy",  busy_a, 0);
    check("rst_async_valid", valid_a, 0);
    check("rst_async_class", cls_a, 0);
    check("rst_async_count", cnt_a, 0);
    check("rst_async_none",  none_a, 0);
    d1 = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_window(1'b0, 16'h0000, 16'hFFFF, 16'h0000, 8'd5, mk(1, CNT16, 0), LAT_EARLY, "post_reset");

    // Backpressure: stall 10 cycles in HOLD with ignored start pulses.
    wait_idle(1'b0, "bp");
    ready = 1'b0;
    exp_a.push_back(mk(0, 4, 0));
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    accum_and_wait(1'b0, 16'h000F, 16'h0000, 16'h0000, 8'd9, LAT_FULL, "bp_first");
    for (int i = 0; i < 10; i++) begin
      start_a = i[0];
      @(posedge clk); #1;
      check("bp_valid_held", valid_a, 1);
      check("bp_not_busy",   busy_a, 0);
    end

    // Handshake with start in the same cycle: straight back into ACCUM.
    exp_a.push_back(mk(2, 2, 0));
    start_a = 1'b1;
    ready   = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("b2b_busy",      busy_a, 1);
    check("b2b_valid_low", valid_a, 0);
    accum_and_wait(1'b0, 16'h0000, 16'h0000, 16'h0003, 8'd200, LAT_FULL, "b2b");

    // Saturating counters on the narrow instance.
    run_window(1'b1, 16'h0000, 16'h0000, 16'hFFFF, 8'd255, mk(2, 7, 0), LAT_FULL, "sat");
    run_window(1'b1, 16'h0000, 16'h0000, 16'h0000, 8'd0,   mk(0, 0, 1), LAT_FULL, "sat_zero");

    wait_idle(1'b0, "end_a");
    wait_idle(1'b1, "end_b");
    check("a_queue_drained", exp_a.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_snn_spike_decoder
